// File: rtl/fan_ctrl.sv
// fan_ctrl: Wishbone-mapped PWM fan driver with per-channel tach counters.
// Stall detection and IRQ are built only when FAN_STALL_IRQ_EN is defined.
module fan_tach_ch #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fan,
  input  logic             term,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] tach
);
  logic s1, s2, hist, fall;
  assign fall = hist & ~s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
      live <= '0;
      tach <= '0;
    end else begin
      s1   <= fan;
      s2   <= s1;
      hist <= s2;
      // an edge seen on the terminal cycle belongs to the next window
      if (term) begin
        tach <= live;
        live <= {{(CNT_W-1){1'b0}}, fall};
      end else if (fall && !(&live)) begin
        live <= live + 1'b1;
      end
    end
  end
endmodule

module fan_ctrl #(
  parameter int CH_NUM  = 4,
  parameter int PWM_W   = 10,
  parameter int CNT_W   = 26,
  parameter int WIN_CYC = 50000000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              FAN_STB_I,
  input  logic              FAN_WE_I,
  input  logic [5:0]        FAN_ADR_I,
  input  logic [31:0]       FAN_DAT_I,
  input  logic [3:0]        FAN_SEL_I,
  input  logic              FAN_CYC_I,
  input  logic              FAN_LOCK_I,
  input  logic [2:0]        FAN_CTI_I,
  input  logic [1:0]        FAN_BTE_I,
  output logic              FAN_ACK_O,
  output logic [31:0]       FAN_DAT_O,
  output logic              FAN_ERR_O,
  output logic              FAN_RTY_O,
  output logic [CH_NUM-1:0] PWM_O,
  input  logic [CH_NUM-1:0] FAN_IN,
  output logic              IRQ_O
);
  localparam int WIN_W = $clog2(WIN_CYC);

  logic                         access, wr, term, pwm_en;
  logic [3:0]                   idx, stat, mask;
  logic [CH_NUM-1:0][PWM_W-1:0] duty_sh, duty_act;
  logic [CH_NUM-1:0][CNT_W-1:0] live, tach;
  logic [PWM_W-1:0]             cnt;
  logic [WIN_W-1:0]             win;
  logic [CNT_W-1:0]             thr;
  logic [31:0]                  rd;
  logic                         unused_in;

  assign access    = FAN_STB_I & ~FAN_ACK_O;
  assign wr        = access & FAN_WE_I;
  assign idx       = FAN_ADR_I[5:2];
  assign term      = (win == WIN_W'(WIN_CYC - 1));
  assign FAN_ERR_O = 1'b0;
  assign FAN_RTY_O = 1'b0;
  assign unused_in = ^{FAN_SEL_I, FAN_CYC_I, FAN_LOCK_I, FAN_CTI_I, FAN_BTE_I,
                       FAN_ADR_I[1:0], FAN_DAT_I};

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      FAN_ACK_O <= 1'b0;
      FAN_DAT_O <= '0;
      cnt       <= '0;
      win       <= '0;
      pwm_en    <= 1'b0;
      duty_sh   <= '0;
      duty_act  <= '0;
    end else begin
      FAN_ACK_O <= access;
      FAN_DAT_O <= (access & ~FAN_WE_I) ? rd : '0;
      cnt       <= cnt + 1'b1;
      win       <= term ? '0 : win + 1'b1;
      if (wr && idx == 4'd8) pwm_en <= FAN_DAT_I[0];
      for (int n = 0; n < CH_NUM; n++) begin
        if (wr && idx == 4'(n)) duty_sh[n] <= FAN_DAT_I[PWM_W-1:0];
        // duty swaps only as the counter wraps, so no period is cut short
        if (&cnt) duty_act[n] <= duty_sh[n];
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign PWM_O[g] = pwm_en & (cnt < duty_act[g]);
    fan_tach_ch #(.CNT_W(CNT_W)) u_ch (
      .clk (CLK_I),
      .rst (RST_I),
      .fan (FAN_IN[g]),
      .term(term),
      .live(live[g]),
      .tach(tach[g])
    );
  end

  always_comb begin
    rd = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (idx == 4'(n))     rd = 32'(duty_sh[n]);
      if (idx == 4'(n + 4)) rd = 32'(tach[n]);
    end
    case (idx)
      4'd8:    rd = {20'd0, mask, 7'd0, pwm_en};
      4'd9:    rd = {28'd0, stat};
      4'd10:   rd = 32'(thr);
      default: ;
    endcase
  end

`ifdef FAN_STALL_IRQ_EN
  logic [3:0] stall_set, clr;

  always_comb begin
    stall_set = '0;
    for (int n = 0; n < CH_NUM; n++)
      stall_set[n] = term && (thr != '0) && (live[n] < thr);
  end
  assign clr = (wr && idx == 4'd9) ? FAN_DAT_I[3:0] : 4'd0;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      stat <= '0;
      mask <= '0;
      thr  <= '0;
    end else begin
      stat <= (stat & ~clr) | stall_set;
      if (wr && idx == 4'd8)  mask <= FAN_DAT_I[11:8];
      if (wr && idx == 4'd10) thr  <= FAN_DAT_I[CNT_W-1:0];
    end
  end
  assign IRQ_O = |(stat & mask);
`else
  logic unused_live;
  assign unused_live = ^live;
  assign stat  = '0;
  assign mask  = '0;
  assign thr   = '0;
  assign IRQ_O = 1'b0;
`endif
endmodule
